dec138_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 3-to-8 decoder (74138-type) among 8 requesters.

---
 rtl/dec138_sched_pkg.sv | 11 +
 rtl/rr_pick8.sv | 23 ++
 rtl/dec138_rr_sched.sv | 121 ++++++++++++
 tb/tb_dec138_rr_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dec138_sched_pkg.sv
// Shared types and constants for the 74138 round-robin scheduler.
// Enable patterns are packed as {g1, g2a_n, g2b_n}.
package dec138_sched_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {IDLE, SETUP, GRANT, GUARD} state_t;

    localparam logic [2:0] ENA_ON  = 3'b100;
    localparam logic [2:0] ENA_OFF = 3'b011;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... mod 8.
module rr_pick8
    import dec138_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   win,
    output logic               any
);
    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the nearest hit after 'last' wins.
    always_comb begin
        win = last;
        idx = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + IDX_W'(i);
            if (req[idx]) win = idx;
        end
    end

    assign any = |req;
endmodule

// File: rtl/dec138_rr_sched.sv
// Round-robin scheduler sharing one 74138 decoder among 8 requesters, with
// break-before-make sequencing (SETUP before enabling, GUARD gap after each grant).
module dec138_rr_sched
    import dec138_sched_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned MAX_HOLD     = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic               select_a_o,
    output logic               select_b_o,
    output logic               select_c_o,
    output logic               g1_en_o,
    output logic               g2a_en_n_o,
    output logic               g2b_en_n_o,
    output logic               grant_vld_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               timeout_o
);
    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [3:0] GUARD_LEN = 4'(GUARD_CYCLES);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       hold_q, hold_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [2:0]       ena_q, ena_d;
    logic             vld_q, vld_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] win;
    logic             any;

    rr_pick8 u_pick (
        .req  (req_i),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gcnt_d  = gcnt_q;
        ena_d   = ENA_OFF;
        vld_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && any) begin
                    sel_d   = win;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Selects have been stable for a cycle; only now may the decoder turn on.
                if (en_i && req_i[sel_q]) begin
                    state_d = GRANT;
                    ena_d   = ENA_ON;
                    vld_d   = 1'b1;
                    last_d  = sel_q;
                    hold_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!en_i || !req_i[sel_q]) begin
                    state_d = GUARD;
                    gcnt_d  = 4'd1;
                end else if (HOLD_MAX != 8'd0 && hold_q == HOLD_MAX) begin
                    state_d = GUARD;
                    gcnt_d  = 4'd1;
                    to_d    = 1'b1;
                end else begin
                    ena_d  = ENA_ON;
                    vld_d  = 1'b1;
                    hold_d = hold_q + 8'd1;
                end
            end
            GUARD: begin
                if (gcnt_q == GUARD_LEN) state_d = IDLE;
                else                     gcnt_d  = gcnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= '1;
            hold_q  <= '0;
            gcnt_q  <= '0;
            ena_q   <= ENA_OFF;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gcnt_q  <= gcnt_d;
            ena_q   <= ena_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end

    assign {select_c_o, select_b_o, select_a_o} = sel_q;
    assign {g1_en_o, g2a_en_n_o, g2b_en_n_o}    = ena_q;
    assign grant_vld_o = vld_q;
    assign grant_idx_o = sel_q;
    assign timeout_o   = to_q;
endmodule

// File: tb/tb_dec138_rr_sched.sv
// Bench for dec138_rr_sched: directed vector table, hand sequences, and random
// stimulus against a behavioural scheduler model; outputs feed a 74138 model.
module tb_dec138_rr_sched;
    localparam int G  = 2;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;
    logic       sa, sb, sc, g1, g2a_n, g2b_n, vld, tmo;
    logic [2:0] idx;
    logic [7:0] yn;

    int n_pass = 0;
    int n_tot  = 0;

    dec138_rr_sched #(.GUARD_CYCLES(G), .MAX_HOLD(MH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .req_i(req),
        .select_a_o(sa), .select_b_o(sb), .select_c_o(sc),
        .g1_en_o(g1), .g2a_en_n_o(g2a_n), .g2b_en_n_o(g2b_n),
        .grant_vld_o(vld), .grant_idx_o(idx), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    // 74138: output k low only when fully enabled and {C,B,A}==k
    assign yn = (g1 && !g2a_n && !g2b_n) ? ~(8'h01 << {sc, sb, sa}) : 8'hFF;

    wire [9:0] out_vec = {sc, sb, sa, g1, g2a_n, g2b_n, vld, idx, tmo};

    // ---------------- behavioural reference model ----------------
    bit m_on, m_to;
    int m_cand, m_sel, m_last, m_held, m_cool;

    function automatic int rr_pick(input logic [7:0] r, input int last);
        for (int i = 1; i <= 8; i++)
            if (r[(last + i) % 8]) return (last + i) % 8;
        return last;
    endfunction

    task automatic model_reset();
        m_on = 0; m_to = 0; m_cand = -1; m_sel = 0; m_last = 7; m_held = 0; m_cool = 0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] r);
        m_to = 0;
        if (m_on) begin
            if (!e || !r[m_sel]) begin m_on = 0; m_cool = G; end
            else if (MH != 0 && m_held == MH) begin m_on = 0; m_cool = G; m_to = 1; end
            else m_held++;
        end else if (m_cand >= 0) begin
            if (e && r[m_cand]) begin m_on = 1; m_held = 1; m_last = m_cand; end
            m_cand = -1;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (e && r != 8'h00) begin
            m_cand = rr_pick(r, m_last);
            m_sel  = m_cand;
        end
    endtask

    function automatic logic [9:0] pack_exp(input int s, input bit on, input bit t);
        logic [2:0] s3;
        s3 = 3'(s);
        return {s3, on, !on, !on, on, s3, t};
    endfunction

    function automatic logic [7:0] exp_yn(input int s, input bit on);
        logic [7:0] one;
        one = 8'h01;
        return on ? ~(one << s) : 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // ---------------- cycle driver with invariant checks ----------------
    logic [2:0] prev_sel = 3'd0;
    logic       prev_g1  = 1'b0;

    task automatic cyc(input logic e, input logic [7:0] r);
        en = e; req = r;
        @(posedge clk);
        model_step(e, r);
        #1;
        if (g1 || prev_g1) chk("sel_stable_while_on", {13'd0, sc, sb, sa}, {13'd0, prev_sel});
        chk("ena_not_mixed", 16'({g1, g2a_n, g2b_n} == 3'b100 || {g1, g2a_n, g2b_n} == 3'b011), 16'd1);
        prev_sel = {sc, sb, sa};
        prev_g1  = g1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; req = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 16'(out_vec), 16'(pack_exp(0, 0, 0)));
        chk("reset_yn", 16'(yn), 16'hFF);
        rst_n = 1'b1;
        model_reset();
        prev_sel = 3'd0; prev_g1 = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [2:0] sel;
        logic       on;
        logic       to;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic [7:0] r, input logic [2:0] s,
                                input logic on, input logic t);
        vec_t v;
        v.en = e; v.req = r; v.sel = s; v.on = on; v.to = t;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed table: single grant, guard ignores req, 1-cycle pulse, en drop on idx 5
        tbl.push_back(mk(1, 8'h04, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h04, 3'd2, 1, 0));
        tbl.push_back(mk(1, 8'h04, 3'd2, 1, 0));
        tbl.push_back(mk(1, 8'h00, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h01, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h01, 3'd2, 0, 0));
        tbl.push_back(mk(1, 8'h01, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h01, 3'd0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd0, 0, 0));
        tbl.push_back(mk(1, 8'h08, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h09, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h09, 3'd3, 1, 0));
        tbl.push_back(mk(1, 8'h00, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd3, 0, 0));
        tbl.push_back(mk(1, 8'h20, 3'd5, 0, 0));
        tbl.push_back(mk(1, 8'h20, 3'd5, 1, 0));
        tbl.push_back(mk(0, 8'h20, 3'd5, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h20, 3'd5, 0, 0));
        tbl.push_back(mk(1, 8'h20, 3'd5, 0, 0));
        tbl.push_back(mk(1, 8'h20, 3'd5, 1, 0));
        tbl.push_back(mk(1, 8'h00, 3'd5, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd5, 0, 0));
        tbl.push_back(mk(1, 8'h00, 3'd5, 0, 0));

        // Reset, then idle with no requests
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'h00);
            chk("idle_outputs", 16'(out_vec), 16'(pack_exp(0, 0, 0)));
            chk("idle_yn", 16'(yn), 16'hFF);
        end

        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].req);
            chk($sformatf("vec%0d_out", i), 16'(out_vec), 16'(pack_exp(tbl[i].sel, tbl[i].on, tbl[i].to)));
            chk($sformatf("vec%0d_yn", i), 16'(yn), 16'(exp_yn(tbl[i].sel, tbl[i].on)));
        end

        // All requesting with MAX_HOLD=4: grants 0..7,0, each 4 on + timeout + 4 off
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            for (int c = 1; c <= 8; c++) begin
                cyc(1'b1, 8'hFF);
                chk($sformatf("rr_k%0d_c%0d", k, c), 16'(out_vec),
                    16'(pack_exp(k % 8, (c >= 2 && c <= 5), (c == 6))));
            end
        end
        // Reset mid-grant drops enables without a clock edge
        for (int c = 1; c <= 3; c++) cyc(1'b1, 8'hFF);
        chk("pre_reset_on", 16'({g1, g2a_n, g2b_n}), 16'(3'b100));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ena", 16'({g1, g2a_n, g2b_n, vld}), 16'(4'b0110));
        chk("async_reset_yn", 16'(yn), 16'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev_sel = 3'd0; prev_g1 = 1'b0;

        // Random stimulus against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] r;
            logic       e;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            e = ($urandom_range(0, 9) != 0);
            cyc(e, r);
            chk("rand_out", 16'(out_vec), 16'(pack_exp(m_sel, m_on, m_to)));
            chk("rand_yn", 16'(yn), 16'(exp_yn(m_sel, m_on)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
